ov7670_frame_ctrl: RTL and testbench

Frame-level sequencer for the OV7670 capture path, running in the pclk_24 domain. It waits for sensor register configuration to complete, aligns to a clean frame boundary on vsync, and gates capture through capture_en. It also counts bytes per line and lines per frame, and reports frame start/done/error events to the buffer controller and system logic. It supports single-shot and continuous capture, plus a graceful stop.

---
 rtl/ov7670_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ov7670_frame_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_frame_ctrl.sv
// OV7670 frame-level capture sequencer: waits for sensor config, aligns to vsync,
// gates capture_en, checks line/frame geometry and reports frame events.
module ov7670_frame_ctrl #(
  parameter int unsigned H_BYTES = 640,
  parameter int unsigned V_LINES = 240,
  parameter int unsigned HCNT_W  = 10,
  parameter int unsigned VCNT_W  = 9
) (
  input  logic              pclk_24,
  input  logic              reset_n,
  input  logic              cfg_done,
  input  logic              arm,
  input  logic              continuous,
  input  logic              stop,
  input  logic              vsync,
  input  logic              href,
  output logic              capture_en,
  output logic              busy,
  output logic              frame_start,
  output logic              frame_done,
  output logic              frame_err,
  output logic [VCNT_W-1:0] line_cnt
);

  localparam logic [HCNT_W-1:0] H_EXP = HCNT_W'(H_BYTES);
  localparam logic [HCNT_W-1:0] H_MAX = HCNT_W'(H_BYTES + 1);
  localparam logic [VCNT_W-1:0] V_EXP = VCNT_W'(V_LINES);
  localparam logic [VCNT_W-1:0] V_MAX = VCNT_W'(V_LINES + 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_VS_HIGH = 2'd1,
    WAIT_VS_LOW  = 2'd2,
    ACTIVE       = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                cfg_m_q, cfg_m_d, cfg_s_q, cfg_s_d;
  logic                vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic                hr_q, hr_d, hr_prev_q, hr_prev_d;
  logic                cont_q, cont_d;
  logic                stop_pend_q, stop_pend_d;
  logic                err_q, err_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [VCNT_W-1:0]   line_cnt_q, line_cnt_d;
  logic                capture_en_q, capture_en_d;
  logic                busy_q, busy_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_err_q, frame_err_d;

  logic vs_rise, vs_fall, hr_fall;
  assign vs_rise = vs_q & ~vs_prev_q;
  assign vs_fall = ~vs_q & vs_prev_q;
  assign hr_fall = ~hr_q & hr_prev_q;

  always_comb begin
    state_d       = state_q;
    cfg_m_d       = cfg_done;
    cfg_s_d       = cfg_m_q;
    vs_d          = vsync;
    vs_prev_d     = vs_q;
    hr_d          = href;
    hr_prev_d     = hr_q;
    cont_d        = cont_q;
    stop_pend_d   = stop_pend_q;
    err_d         = err_q;
    hcnt_d        = hcnt_q;
    line_cnt_d    = line_cnt_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (arm && cfg_s_q) begin
          cont_d  = continuous;
          state_d = WAIT_VS_HIGH;
        end
      end
      WAIT_VS_HIGH: begin
        // Requiring vsync high first means a frame already in flight is skipped.
        if (!cfg_s_q || stop) state_d = IDLE;
        else if (vs_q)        state_d = WAIT_VS_LOW;
      end
      WAIT_VS_LOW: begin
        if (!cfg_s_q || stop) begin
          state_d = IDLE;
        end else if (vs_fall) begin
          state_d       = ACTIVE;
          frame_start_d = 1'b1;
          hcnt_d        = '0;
          line_cnt_d    = '0;
          err_d         = 1'b0;
        end
      end
      ACTIVE: begin
        if (!cfg_s_q) begin
          state_d = IDLE;
        end else begin
          if (stop) stop_pend_d = 1'b1;
          if (hr_q && hcnt_q != H_MAX) hcnt_d = hcnt_q + HCNT_W'(1);
          if (hr_fall) begin
            hcnt_d = '0;
            if (line_cnt_q != V_MAX) line_cnt_d = line_cnt_q + VCNT_W'(1);
            if (hcnt_q != H_EXP)     err_d      = 1'b1;
          end
          // Error verdict uses the updated line count so a coincident last line is counted.
          if (vs_rise) begin
            frame_done_d = 1'b1;
            frame_err_d  = err_d | (line_cnt_d != V_EXP);
            state_d      = (cont_q && !stop_pend_q && !stop) ? WAIT_VS_LOW : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) stop_pend_d = 1'b0;
    capture_en_d = (state_d == ACTIVE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge pclk_24) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cfg_m_q       <= 1'b0;
      cfg_s_q       <= 1'b0;
      vs_q          <= 1'b0;
      vs_prev_q     <= 1'b0;
      hr_q          <= 1'b0;
      hr_prev_q     <= 1'b0;
      cont_q        <= 1'b0;
      stop_pend_q   <= 1'b0;
      err_q         <= 1'b0;
      hcnt_q        <= '0;
      line_cnt_q    <= '0;
      capture_en_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_m_q       <= cfg_m_d;
      cfg_s_q       <= cfg_s_d;
      vs_q          <= vs_d;
      vs_prev_q     <= vs_prev_d;
      hr_q          <= hr_d;
      hr_prev_q     <= hr_prev_d;
      cont_q        <= cont_d;
      stop_pend_q   <= stop_pend_d;
      err_q         <= err_d;
      hcnt_q        <= hcnt_d;
      line_cnt_q    <= line_cnt_d;
      capture_en_q  <= capture_en_d;
      busy_q        <= busy_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign capture_en  = capture_en_q;
  assign busy        = busy_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign line_cnt    = line_cnt_q;

endmodule

// File: tb/tb_ov7670_frame_ctrl.sv
// Bench for ov7670_frame_ctrl: drives randomized sensor frames (scaled-down geometry)
// and compares per-frame events against a frame-level expectation model.
module tb_ov7670_frame_ctrl;

  localparam int unsigned H  = 16;
  localparam int unsigned V  = 12;
  localparam int unsigned HW = 5;
  localparam int unsigned VW = 4;

  logic          pclk_24 = 1'b0;
  logic          reset_n, cfg_done, arm, continuous, stop, vsync, href;
  logic          capture_en, busy, frame_start, frame_done, frame_err;
  logic [VW-1:0] line_cnt;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_done = 0;
  int bad_pulse = 0;
  logic          last_err = 1'b0;
  logic [VW-1:0] last_line = '0;

  ov7670_frame_ctrl #(.H_BYTES(H), .V_LINES(V), .HCNT_W(HW), .VCNT_W(VW)) dut (
    .pclk_24(pclk_24), .reset_n(reset_n), .cfg_done(cfg_done), .arm(arm),
    .continuous(continuous), .stop(stop), .vsync(vsync), .href(href),
    .capture_en(capture_en), .busy(busy), .frame_start(frame_start),
    .frame_done(frame_done), .frame_err(frame_err), .line_cnt(line_cnt)
  );

  always #5 pclk_24 = ~pclk_24;

  // Event monitor; frame_start must coincide with capture_en rising, frame_done with it falling.
  always @(negedge pclk_24) begin
    if (frame_start) n_start <= n_start + 1;
    if (frame_done) begin
      n_done    <= n_done + 1;
      last_err  <= frame_err;
      last_line <= line_cnt;
    end
    if ((frame_err && !frame_done) || (frame_start && !capture_en) || (frame_done && capture_en))
      bad_pulse <= bad_pulse + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed no end of run, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pclk_24);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_capture_en"}, 32'(capture_en), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_frame_err"}, 32'(frame_err), 0);
    chk({tag, "_line_cnt"}, 32'(line_cnt), 0);
  endtask

  // kinds: 1 stop, 2 cfg abort, 3 reset, 4 arm single, 5 arm continuous,
  // 6 arm continuous then stop while waiting, 7 arm+stop same cycle
  task automatic do_hook(input int kind);
    case (kind)
      1: begin stop = 1'b1; tick(1); stop = 1'b0; end
      2: begin
        cfg_done = 1'b0;
        tick(3);
        chk("abort_capture_en", 32'(capture_en), 0);
        chk("abort_busy", 32'(busy), 0);
        arm = 1'b1; tick(1); arm = 1'b0;
        tick(2);
        chk("arm_no_cfg_busy", 32'(busy), 0);
        cfg_done = 1'b1;
        tick(3);
      end
      3: begin
        reset_n = 1'b0; tick(1); reset_n = 1'b1;
        chk_all_zero("midframe_reset");
      end
      4: begin continuous = 1'b0; arm = 1'b1; tick(1); arm = 1'b0; end
      5: begin continuous = 1'b1; arm = 1'b1; tick(1); arm = 1'b0; continuous = 1'b0; end
      6: begin
        continuous = 1'b1; arm = 1'b1; tick(1); arm = 1'b0; continuous = 1'b0;
        tick(2);
        chk("wait_busy_before_stop", 32'(busy), 1);
        stop = 1'b1; tick(1); stop = 1'b0;
        tick(1);
        chk("wait_stop_busy", 32'(busy), 0);
      end
      7: begin
        continuous = 1'b0; arm = 1'b1; stop = 1'b1; tick(1); arm = 1'b0; stop = 1'b0;
        tick(1);
        chk("arm_stop_busy", 32'(busy), 1);
      end
      default: ;
    endcase
  endtask

  // One sensor frame: front porch, lines, vsync-high gap; then compare events against the model.
  task automatic run_frame(input string tag, input int nlines, input int bad_line, input int bad_len,
                           input bit coincide, input int hook_line, input int hook_kind,
                           input bit exp_start, input bit exp_done);
    int  s0, d0, exp_line;
    bit  exp_err;
    exp_err  = (bad_line >= 0 && bad_line < nlines && bad_len != int'(H)) || (nlines != int'(V));
    exp_line = (nlines > int'(V) + 1) ? int'(V) + 1 : nlines;
    s0 = n_start;
    d0 = n_done;
    vsync = 1'b0;
    tick(int'($urandom_range(3, 6)));
    for (int l = 0; l < nlines; l++) begin
      if (l == hook_line) do_hook(hook_kind);
      href = 1'b1;
      tick((l == bad_line) ? bad_len : int'(H));
      href = 1'b0;
      if (coincide && l == nlines - 1) vsync = 1'b1;
      else tick(int'($urandom_range(2, 5)));
    end
    vsync = 1'b1;
    tick(3);
    chk({tag, "_vs_high_capture_en"}, 32'(capture_en), 0);
    tick(int'($urandom_range(2, 5)));
    chk({tag, "_starts"}, 32'(n_start - s0), 32'(exp_start));
    chk({tag, "_dones"}, 32'(n_done - d0), 32'(exp_done));
    if (exp_done) begin
      chk({tag, "_frame_err"}, 32'(last_err), 32'(exp_err));
      chk({tag, "_line_cnt"}, 32'(last_line), 32'(exp_line));
    end
  endtask

  initial begin
    int nl, bl, blen;
    reset_n = 1'b0; cfg_done = 1'b1; arm = 1'b0; continuous = 1'b0;
    stop = 1'b0; vsync = 1'b1; href = 1'b0;
    tick(3);
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick(4);
    stop = 1'b1; tick(1); stop = 1'b0; tick(1);
    chk("idle_stop_busy", 32'(busy), 0);

    // single-shot, armed mid-frame
    run_frame("ss_armframe", V, -1, H, 1'b0, 3, 4, 1'b0, 1'b0);
    chk("ss_busy_waiting", 32'(busy), 1);
    run_frame("ss_capture", V, -1, H, 1'b0, -1, 0, 1'b1, 1'b1);
    chk("ss_busy_after", 32'(busy), 0);
    run_frame("ss_after", V, -1, H, 1'b0, -1, 0, 1'b0, 1'b0);

    // continuous, stop during the third captured frame
    run_frame("ct_armframe", V, -1, H, 1'b0, 2, 5, 1'b0, 1'b0);
    run_frame("ct_f1", V, -1, H, 1'b0, -1, 0, 1'b1, 1'b1);
    run_frame("ct_f2", V, -1, H, 1'b0, -1, 0, 1'b1, 1'b1);
    run_frame("ct_f3_stop", V, -1, H, 1'b0, 4, 1, 1'b1, 1'b1);
    chk("ct_busy_after_stop", 32'(busy), 0);
    run_frame("ct_f4", V, -1, H, 1'b0, -1, 0, 1'b0, 1'b0);

    // geometry errors: short line, short frame, long frame
    run_frame("ge_arm1", V, -1, H, 1'b0, 1, 4, 1'b0, 1'b0);
    run_frame("ge_shortline", V, 5, H - 1, 1'b0, -1, 0, 1'b1, 1'b1);
    run_frame("ge_arm2", V, -1, H, 1'b0, 1, 4, 1'b0, 1'b0);
    run_frame("ge_shortframe", V - 1, -1, H, 1'b0, -1, 0, 1'b1, 1'b1);
    run_frame("ge_arm3", V, -1, H, 1'b0, 1, 4, 1'b0, 1'b0);
    run_frame("ge_longframe", V + 1, -1, H, 1'b0, -1, 0, 1'b1, 1'b1);

    // cfg_done abort mid-frame
    run_frame("ab_arm", V, -1, H, 1'b0, 2, 4, 1'b0, 1'b0);
    run_frame("ab_abort", V, -1, H, 1'b0, 6, 2, 1'b1, 1'b0);
    run_frame("ab_after", V, -1, H, 1'b0, -1, 0, 1'b0, 1'b0);

    // reset mid-frame
    run_frame("rs_arm", V, -1, H, 1'b0, 2, 5, 1'b0, 1'b0);
    run_frame("rs_reset", V, -1, H, 1'b0, 6, 3, 1'b1, 1'b0);
    run_frame("rs_after1", V, -1, H, 1'b0, -1, 0, 1'b0, 1'b0);
    run_frame("rs_after2", V, -1, H, 1'b0, -1, 0, 1'b0, 1'b0);
    chk("rs_busy", 32'(busy), 0);

    // last href fall coincident with vsync rise
    run_frame("co_arm", V, -1, H, 1'b0, 2, 4, 1'b0, 1'b0);
    run_frame("co_frame", V, -1, H, 1'b1, -1, 0, 1'b1, 1'b1);

    // stop while waiting for alignment; arm and stop together in IDLE
    run_frame("ws_frame", V, -1, H, 1'b0, 3, 6, 1'b0, 1'b0);
    run_frame("ws_after", V, -1, H, 1'b0, -1, 0, 1'b0, 1'b0);
    run_frame("as_arm", V, -1, H, 1'b0, 3, 7, 1'b0, 1'b0);
    run_frame("as_capture", V, -1, H, 1'b0, -1, 0, 1'b1, 1'b1);

    // randomized continuous run with random geometry
    run_frame("rnd_arm", V, -1, H, 1'b0, 2, 5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      nl   = int'(V) - 1 + int'($urandom_range(0, 2));
      bl   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, V - 2)) : -1;
      blen = int'(H) - 2 + int'($urandom_range(0, 4));
      run_frame($sformatf("rnd_f%0d", i), nl, bl, blen, 1'($urandom_range(0, 1)),
                (i == 4) ? 3 : -1, (i == 4) ? 1 : 0, 1'b1, 1'b1);
    end
    chk("rnd_busy_after_stop", 32'(busy), 0);
    run_frame("rnd_after", V, -1, H, 1'b0, -1, 0, 1'b0, 1'b0);

    chk("pulse_alignment", 32'(bad_pulse), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
